// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Holds the FSM state encoding, the requester indices and the one-hot grant helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Two-way round-robin selector: picks from an eligibility mask, and on a tie
// it favours the requester that was not served last.
module mem_bus_arbiter_rr_picker
    import mem_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] eligible,
    input  logic       update,
    input  logic       served,
    output logic [1:0] win,
    output logic       win_idx
);

    logic last;

    // Resetting to the DMA side makes the first tie go to the CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= REQ_DMA;
        end else if (update) begin
            last <= served;
        end
    end

    always_comb begin
        win_idx = REQ_CPU;
        case (eligible)
            2'b10:   win_idx = REQ_DMA;
            2'b11:   win_idx = ~last;
            default: win_idx = REQ_CPU;
        endcase
        win = (eligible == 2'b00) ? 2'b00 : idx_onehot(win_idx);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter serialising CPU and DMA transactions onto the memory controller,
// with round-robin fairness and a bounded bus lock.
//
// state    | meaning
// ST_IDLE  | arbitrate; grant shown combinationally for the winner
// ST_ISSUE | drive address/data, pulse m_read or m_write
// ST_WAIT  | count down read latency, capture m_rdata at zero
// ST_ACK   | pulse ack to owner, update rr pointer and lock count
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  lock,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [1:0]  gnt,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] LAT_INIT = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [4:0] LOCK_MAX = 5'(MAX_LOCK);

    arb_state_t  state, state_d;
    logic        cur, cur_we, locked;
    logic [3:0]  lock_cnt;
    logic [2:0]  lat_cnt;
    logic [31:0] cur_addr, cur_wdata, rdata_q;
    logic [1:0]  eligible, win;
    logic        win_idx, owner_present, capture, pick_update, lock_keep;

    // A locked owner that still requests excludes the other master.
    assign owner_present = locked && req[cur];
    assign eligible      = owner_present ? idx_onehot(cur) : req;
    assign lock_keep     = lock[cur] && (({1'b0, lock_cnt} + 5'd1) < LOCK_MAX);

    mem_bus_arbiter_rr_picker u_picker (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible),
        .update   (pick_update),
        .served   (cur),
        .win      (win),
        .win_idx  (win_idx)
    );

    always_comb begin
        state_d     = state;
        gnt         = 2'b00;
        ack         = 2'b00;
        m_read      = 1'b0;
        m_write     = 1'b0;
        capture     = 1'b0;
        pick_update = 1'b0;
        case (state)
            ST_IDLE: begin
                gnt = win & {2{reset_n}};
                if (eligible != 2'b00) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                gnt = idx_onehot(cur);
                if (cur_we) begin
                    m_write = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    m_read = 1'b1;
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                gnt = idx_onehot(cur);
                if (lat_cnt == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                gnt         = idx_onehot(cur);
                ack         = idx_onehot(cur);
                pick_update = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_addr  = cur_addr;
    assign m_wdata = cur_wdata;
    assign rdata   = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur       <= REQ_CPU;
            cur_we    <= 1'b0;
            cur_addr  <= 32'd0;
            cur_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            locked    <= 1'b0;
            lock_cnt  <= 4'd0;
            lat_cnt   <= 3'd0;
        end else begin
            state <= state_d;
            if (capture) rdata_q <= m_rdata;
            case (state)
                ST_IDLE: begin
                    if (locked && !req[cur]) begin
                        locked   <= 1'b0;
                        lock_cnt <= 4'd0;
                    end
                    if (eligible != 2'b00) begin
                        cur       <= win_idx;
                        cur_we    <= we[win_idx];
                        cur_addr  <= (win_idx == REQ_DMA) ? addr1 : addr0;
                        cur_wdata <= (win_idx == REQ_DMA) ? wdata1 : wdata0;
                    end
                end
                ST_ISSUE: lat_cnt <= LAT_INIT;
                ST_WAIT: begin
                    if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
                end
                ST_ACK: begin
                    if (lock_keep) begin
                        locked   <= 1'b1;
                        lock_cnt <= lock_cnt + 4'd1;
                    end else begin
                        locked   <= 1'b0;
                        lock_cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter sharing the CPU-side memory-mapped bus (memory controller → RAM/ROM/keyboard/display) between the RV32 core (requester 0) and a second master such as a DMA/blit engine (requester 1). It serialises transactions with a req/ack handshake and round-robin fairness. It also supports an optional bounded bus lock for back-to-back sequences. It sits between the masters and the memory controller in the clk_100 domain.

Parameters:
READ_LATENCY, 1, cycles from m_read pulse to valid m_rdata (0..7; RAM_B = 1)
MAX_LOCK, 4, max consecutive transactions one locked requester may hold the bus (1..15)

Ports:
clk  in  1  system clock (clk_100 domain)
reset_n  in  1  asynchronous, active-low reset
req  in  2  per-requester transaction request, held until ack
we  in  2  per-requester 1=write, 0=read
lock  in  2  per-requester: keep grant after this transaction
addr0, addr1  in  32  request address
wdata0, wdata1  in  32  write data
ack  out  2  one-cycle completion pulse per requester
rdata  out  32  read data, valid in ack cycle
gnt  out  2  one-hot current owner, 0 when idle
m_addr  out  32  to memory controller
m_wdata  out  32  to memory controller
m_read  out  1  one-cycle read strobe
m_write  out  1  one-cycle write strobe
m_rdata  in  32  from memory controller

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer favours requester 0; lock counter 0; no owner.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Owner locked: only the owner is eligible.
  - Otherwise, with one req, it wins; with both, the one not served last wins (first tie after reset → requester 0).
  - Latch winner's addr/wdata/we, set gnt, go ISSUE.
  - No req → stay IDLE, gnt=0.
- ISSUE (1 cycle): drive m_addr/m_wdata from latches; pulse m_write or m_read.
  - Write → ACK.
  - Read with READ_LATENCY=0 → capture m_rdata now → ACK.
  - Read otherwise → WAIT, counter=READ_LATENCY-1.
- WAIT: m_read low, m_addr held. Decrement counter; at 0 capture m_rdata → ACK.
- ACK (1 cycle): pulse ack[owner]; rdata = captured value for reads, last value retained for writes. Update rr pointer to owner.
  - If lock[owner]=1 in this cycle and lock count+1 < MAX_LOCK, increment the count and keep the owner.
  - Otherwise clear the owner and count (forced release).
  - → IDLE.
- Latency: write 3 cycles req→ack; read 3+READ_LATENCY.
- Requests sampled only in IDLE; changes to addr/wdata/we after grant are ignored.
- req dropped mid-transaction: the transaction completes and ack still pulses (master violation, not aborted).
- Locked owner with req low in IDLE: the lock is released immediately, the other requester is eligible the same cycle, and the count is cleared.
- Forced release at MAX_LOCK: the pointer update makes the other requester win the next tie.
- Asynchronous reset mid-transaction: strobes and ack drop immediately; no ack is ever issued for the aborted transaction.
- Widths: lock counter 4 bits; latency counter 3 bits; gnt always one-hot or zero.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/WAIT/ACK) and requester index constants (REQ_CPU=0, REQ_DMA=1).
- Natural sub-module: rr_picker (2-way round-robin select from req mask plus last-served pointer, combinational plus pointer register).

Test Plan:
1. Reset, then req=01, we=01, addr0=0x10, wdata0=0xDEADBEEF → m_write pulses in cycle 2 with that addr/data; ack=01 in cycle 3; gnt=01 during cycles 1–3.
2. Read req1, addr1=0x20, m_rdata=0x12345678 one cycle after m_read (READ_LATENCY=1) → ack=10 and rdata=0x12345678 in cycle 4.
3. Both req held continuously, no lock → grants alternate 0,1,0,1; first grant is 0; each ack separated by exactly 3 cycles.
4. Both req high, lock0=1, MAX_LOCK=4 → four consecutive acks to requester 0, then requester 1 granted; lock count resets.
5. reset_n low during WAIT → m_read, ack, gnt go 0 asynchronously; after release, first pending req re-arbitrates from the IDLE reset state.
6. req0 dropped in ISSUE → ack0 still pulses once; arbiter returns to IDLE with no further strobes.
